// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants and types for the PWM bank
package pwm_pkg;
    localparam int ALIGN_EDGE   = 0;
    localparam int ALIGN_CENTER = 1;
    localparam int CH_W         = 5;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;
endpackage

// File: rtl/pwm_bank_if.sv
// rtl/pwm_bank_if.sv - duty write port bundle for the PWM bank
interface pwm_bank_if #(
    parameter int RES = 8
) ();
    logic                     wr_valid;
    logic [pwm_pkg::CH_W-1:0] wr_ch;
    logic [RES-1:0]           wr_data;

    modport master (output wr_valid, wr_ch, wr_data);
    modport slave  (input  wr_valid, wr_ch, wr_data);
endinterface

// File: rtl/pwm_timebase.sv
// rtl/pwm_timebase.sv - prescaler, shared period counter and period boundary
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int RES     = 8,
    parameter int PRESC_W = 8,
    parameter int ALIGN   = ALIGN_EDGE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PRESC_W-1:0] i_presc,
    output logic [RES-1:0]     o_cnt,
    output logic               o_boundary,
    output logic               o_period_start
);
    localparam logic [RES-1:0]     CNT_MAX = '1;
    localparam logic [RES-1:0]     CNT_ONE = RES'(1);
    localparam logic [PRESC_W-1:0] PC_ONE  = PRESC_W'(1);

    logic [PRESC_W-1:0] r_pcnt;
    logic [PRESC_W-1:0] r_plim;
    logic [RES-1:0]     r_cnt;
    dir_e               r_dir;
    logic               r_period_start;

    logic [PRESC_W-1:0] w_lim;
    logic               w_tick;
    logic               w_boundary;
    logic [RES-1:0]     w_cnt_nxt;
    dir_e               w_dir_nxt;

    // The reload cycle looks at live presc so a new divider applies from that cycle on.
    assign w_lim  = (r_pcnt == '0) ? i_presc : r_plim;
    assign w_tick = (r_pcnt == w_lim);
    assign w_boundary = (ALIGN == ALIGN_CENTER)
                      ? (w_tick && (r_dir == DIR_DOWN) && (r_cnt == CNT_ONE))
                      : (w_tick && (r_cnt == CNT_MAX));

    always_comb begin
        w_cnt_nxt = r_cnt;
        w_dir_nxt = r_dir;
        if (w_tick) begin
            if (ALIGN == ALIGN_CENTER) begin
                if (r_dir == DIR_UP) begin
                    if (r_cnt == CNT_MAX) begin
                        w_dir_nxt = DIR_DOWN;
                        w_cnt_nxt = r_cnt - CNT_ONE;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end else begin
                    if (r_cnt == CNT_ONE) begin
                        w_dir_nxt = DIR_UP;
                    end
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end else begin
                w_cnt_nxt = r_cnt + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcnt         <= '0;
            r_plim         <= '0;
            r_cnt          <= '0;
            r_dir          <= DIR_UP;
            r_period_start <= 1'b0;
        end else begin
            if (r_pcnt == '0) begin
                r_plim <= i_presc;
            end
            r_pcnt         <= w_tick ? '0 : (r_pcnt + PC_ONE);
            r_cnt          <= w_cnt_nxt;
            r_dir          <= w_dir_nxt;
            r_period_start <= w_boundary;
        end
    end

    assign o_cnt          = r_cnt;
    assign o_boundary     = w_boundary;
    assign o_period_start = r_period_start;
endmodule

// File: rtl/pwm_bank.sv
// rtl/pwm_bank.sv - multi-channel PWM with shadowed duty registers
module pwm_bank
    import pwm_pkg::*;
#(
    parameter int NCH     = 16,
    parameter int RES     = 8,
    parameter int PRESC_W = 8,
    parameter int ALIGN   = ALIGN_EDGE
) (
    input  logic               clk,
    input  logic               rst,
    pwm_bank_if.slave          wr,
    input  logic [NCH-1:0]     en_out,
    input  logic [NCH-1:0]     en_pwm,
    input  logic [PRESC_W-1:0] presc,
    output logic [NCH-1:0]     out,
    output logic               period_start
);
    localparam logic [RES-1:0] DUTY_MAX = '1;

    logic [RES-1:0] r_shadow [NCH];
    logic [RES-1:0] r_active [NCH];
    logic [NCH-1:0] r_out;

    logic [RES-1:0] w_cnt;
    logic           w_boundary;
    logic [NCH-1:0] w_level;

    pwm_timebase #(
        .RES     (RES),
        .PRESC_W (PRESC_W),
        .ALIGN   (ALIGN)
    ) u_timebase (
        .clk            (clk),
        .rst            (rst),
        .i_presc        (presc),
        .o_cnt          (w_cnt),
        .o_boundary     (w_boundary),
        .o_period_start (period_start)
    );

    // Out-of-range channel indices match no loop index and are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (wr.wr_valid && (wr.wr_ch == CH_W'(i))) begin
                    r_shadow[i] <= wr.wr_data;
                end
                if (w_boundary) begin
                    r_active[i] <= r_shadow[i];
                end
            end
        end
    end

    always_comb begin
        w_level = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!en_out[i]) begin
                w_level[i] = 1'b0;
            end else if (!en_pwm[i]) begin
                w_level[i] = 1'b1;
            end else begin
                w_level[i] = (r_active[i] == DUTY_MAX) || (w_cnt < r_active[i]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out <= '0;
        end else begin
            r_out <= w_level;
        end
    end

    assign out = r_out;
endmodule
